// File: rtl/logic_result_stage.sv
// logic_result_stage
//   Two-entry skid buffer that registers the result of the upstream logic
//   unit together with its op tag. A main register drives the outputs, and a
//   skid register absorbs one extra entry when downstream stalls.
//   in_ready comes straight from a flop, so there is no combinational path
//   from out_ready to in_ready.
//
//   Build option (macro):
//     LOGIC_RESULT_FLAGS_EN  defined   -> out_zero/out_msb are computed at
//                                         capture and stored in both entries.
//                            undefined -> out_zero/out_msb are tied to 0 and
//                                         no flag storage exists.
//
//   Handshake: a word moves across a port on a rising clk edge when both its
//   valid and ready are 1 at that edge. Once valid is raised it stays up, and
//   its payload stays unchanged, until the edge that transfers it.
//
//   dbg_state exposes the FSM state (0 EMPTY, 1 ONE, 2 FULL) so checkers can
//   bind to it.

module logic_result_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  // upstream side
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic [1:0]   in_op,
  // downstream side
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [1:0]   out_op,
  output logic         out_zero,
  output logic         out_msb,
  // debug
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic [N-1:0] main_res_q, main_res_d;
  logic [1:0]   main_op_q, main_op_d;
  logic [N-1:0] skid_res_q, skid_res_d;
  logic [1:0]   skid_op_q, skid_op_d;

  logic accept;
  logic consume;
  logic load_main_from_in;
  logic load_main_from_skid;
  logic load_skid_from_in;

  // A word moves in on accept and out on consume. The FULL check is
  // redundant with in_ready_q, but it keeps the FSM safe by construction.
  always_comb begin
    accept  = in_valid && in_ready_q && (state_q != ST_FULL);
    consume = (state_q != ST_EMPTY) && out_ready;
  end

  // Next-state logic and the load strobes for the data registers.
  always_comb begin
    state_d             = state_q;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid_from_in   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d           = ST_ONE;
          load_main_from_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          // The head leaves and the new word replaces it on the same edge.
          state_d           = ST_ONE;
          load_main_from_in = 1'b1;
        end else if (accept) begin
          state_d           = ST_FULL;
          load_skid_from_in = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Upstream is blocked here; only a consume can change anything.
        if (consume) begin
          state_d             = ST_ONE;
          load_main_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Ready for the next cycle is a pure function of the next state.
    in_ready_d = (state_d != ST_FULL);
  end

  // Data path: the registers hold their value unless a load strobe fires.
  always_comb begin
    main_res_d = main_res_q;
    main_op_d  = main_op_q;
    skid_res_d = skid_res_q;
    skid_op_d  = skid_op_q;
    if (load_main_from_in) begin
      main_res_d = in_result;
      main_op_d  = in_op;
    end else if (load_main_from_skid) begin
      main_res_d = skid_res_q;
      main_op_d  = skid_op_q;
    end
    if (load_skid_from_in) begin
      skid_res_d = in_result;
      skid_op_d  = in_op;
    end
  end

  // State, ready and payload registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      main_res_q <= '0;
      main_op_q  <= 2'b00;
      skid_res_q <= '0;
      skid_op_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_res_q <= main_res_d;
      main_op_q  <= main_op_d;
      skid_res_q <= skid_res_d;
      skid_op_q  <= skid_op_d;
    end
  end

`ifdef LOGIC_RESULT_FLAGS_EN
  logic in_zero;
  logic in_msb;
  logic main_zero_q, main_zero_d;
  logic main_msb_q, main_msb_d;
  logic skid_zero_q, skid_zero_d;
  logic skid_msb_q, skid_msb_d;

  // Flags are decoded from the incoming word and then travel with it.
  always_comb begin
    in_zero     = (in_result == '0);
    in_msb      = in_result[N-1];
    main_zero_d = main_zero_q;
    main_msb_d  = main_msb_q;
    skid_zero_d = skid_zero_q;
    skid_msb_d  = skid_msb_q;
    if (load_main_from_in) begin
      main_zero_d = in_zero;
      main_msb_d  = in_msb;
    end else if (load_main_from_skid) begin
      main_zero_d = skid_zero_q;
      main_msb_d  = skid_msb_q;
    end
    if (load_skid_from_in) begin
      skid_zero_d = in_zero;
      skid_msb_d  = in_msb;
    end
  end

  // Flag registers share the data path's load strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_zero_q <= 1'b0;
      main_msb_q  <= 1'b0;
      skid_zero_q <= 1'b0;
      skid_msb_q  <= 1'b0;
    end else begin
      main_zero_q <= main_zero_d;
      main_msb_q  <= main_msb_d;
      skid_zero_q <= skid_zero_d;
      skid_msb_q  <= skid_msb_d;
    end
  end

  assign out_zero = main_zero_q;
  assign out_msb  = main_msb_q;
`else
  assign out_zero = 1'b0;
  assign out_msb  = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_result = main_res_q;
  assign out_op     = main_op_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// tb_logic_result_stage
//   Directed and random bench for logic_result_stage (N = 4). Expected
//   entries are built by a small reference model when an input transfer is
//   seen, and they are compared in order when an output transfer is seen.
//   The flag expectations follow LOGIC_RESULT_FLAGS_EN.

module tb_logic_result_stage;

  localparam int N  = 4;
  localparam int EW = N + 4;   // {zero, msb, op[1:0], result[N-1:0]}
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_result;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [1:0]   out_op;
  logic         out_zero;
  logic         out_msb;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int n_out = 0;

  logic [EW-1:0] exp_q[$];
  logic          hold_pending = 1'b0;
  logic [N-1:0]  held_res;
  logic [1:0]    held_op;

  logic_result_stage #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_msb    (out_msb),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: the entry a captured word should produce.
  function automatic logic [EW-1:0] model(input logic [N-1:0] res, input logic [1:0] op);
    logic z, m;
`ifdef LOGIC_RESULT_FLAGS_EN
    z = (res == '0);
    m = res[N-1];
`else
    z = 1'b0;
    m = 1'b0;
`endif
    return {z, m, op, res};
  endfunction

  // Scoreboard monitor, sampled on the falling edge. Pop before push, so a
  // word accepted this cycle can never be matched against this cycle's output.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (hold_pending) begin
        check_eq("stable_result", 32'(out_result), 32'(held_res));
        check_eq("stable_op", 32'(out_op), 32'(held_op));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_result", 32'(out_result), 32'(e[N-1:0]));
          check_eq("out_op", 32'(out_op), 32'(e[N+1:N]));
          check_eq("out_msb", 32'(out_msb), 32'(e[N+2]));
          check_eq("out_zero", 32'(out_zero), 32'(e[N+3]));
          n_out++;
        end
      end
      hold_pending = out_valid && !out_ready;
      held_res     = out_result;
      held_op      = out_op;
      if (in_valid && in_ready) exp_q.push_back(model(in_result, in_op));
    end else begin
      hold_pending = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] r, input logic [1:0] op);
    in_valid  = v;
    in_result = r;
    in_op     = op;
  endtask

  // Check reset values asynchronously and the in_ready release timing.
  task automatic reset_and_check(input string tag);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_out_result"}, 32'(out_result), 32'd0);
    check_eq({tag, "_out_op"}, 32'(out_op), 32'd0);
    check_eq({tag, "_flags"}, {30'd0, out_zero, out_msb}, 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_EMPTY));
    drive(1'b0, '0, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq({tag, "_ready_before_edge"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq({tag, "_ready_after_edge"}, 32'(in_ready), 32'd1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start_out;
    int budget;
    logic [N-1:0] stream_vals [4];
    stream_vals[0] = 4'b0000;
    stream_vals[1] = 4'b0001;
    stream_vals[2] = 4'b0011;
    stream_vals[3] = 4'b1111;

    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 2'b00);
    #2;
    reset_and_check("por");

    // Single pass: one-cycle latency from EMPTY.
    out_ready = 1'b1;
    drive(1'b1, 4'b0001, 2'b00);
    @(negedge clk);
    check_eq("single_latency_not_yet", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, '0, 2'b00);
    @(negedge clk);
    check_eq("single_out_valid", 32'(out_valid), 32'd1);
    check_eq("single_out_result", 32'(out_result), 32'h1);
    tick();
    @(negedge clk);
    check_eq("single_empty_after", 32'(out_valid), 32'd0);
    tick();

    // Stall fill: two words fill the stage and the third is refused.
    out_ready = 1'b0;
    drive(1'b1, 4'b1001, 2'b01);
    tick();
    drive(1'b1, 4'b1011, 2'b10);
    tick();
    drive(1'b1, 4'b1111, 2'b11);
    @(negedge clk);
    check_eq("fill_state_full", 32'(dbg_state), 32'(ST_FULL));
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    check_eq("fill_head", 32'(out_result), 32'b1001);
    tick();
    tick();
    @(negedge clk);
    check_eq("fill_head_held", 32'(out_result), 32'b1001);
    check_eq("fill_in_ready_held", 32'(in_ready), 32'd0);
    tick();

    // Drain: 1001, then 1011, then empty.
    drive(1'b0, '0, 2'b00);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("drain_first", 32'(out_result), 32'b1001);
    tick();
    @(negedge clk);
    check_eq("drain_second", 32'(out_result), 32'b1011);
    check_eq("drain_in_ready1", 32'(in_ready), 32'd1);
    tick();
    @(negedge clk);
    check_eq("drain_empty", 32'(out_valid), 32'd0);
    check_eq("drain_in_ready2", 32'(in_ready), 32'd1);
    check_eq("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Streaming: full throughput, one word per cycle on each side.
    start_out = n_out;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream_vals[i], 2'(i));
      @(negedge clk);
      check_eq("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    drive(1'b0, '0, 2'b00);
    @(negedge clk);
    check_eq("stream_last_present", 32'(out_result), 32'b1111);
    tick();
    @(negedge clk);
    check_eq("stream_count", 32'(n_out - start_out), 32'd4);
    tick();

    // Reset in the middle of FULL discards both entries.
    out_ready = 1'b0;
    drive(1'b1, 4'b0110, 2'b01);
    tick();
    drive(1'b1, 4'b0111, 2'b10);
    tick();
    drive(1'b0, '0, 2'b00);
    @(negedge clk);
    check_eq("pre_reset_full", 32'(dbg_state), 32'(ST_FULL));
    reset_and_check("mid_reset");

    // Random traffic.
    for (int c = 0; c < 1000; c++) begin
      if (!(in_valid && !in_ready)) begin
        drive(1'($urandom_range(0, 1)), N'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      end
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drive(1'b0, '0, 2'b00);
    out_ready = 1'b1;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    @(negedge clk);
    check_eq("random_drained", 32'(exp_q.size()), 32'd0);
    check_eq("random_final_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
